matrix_elem_alu: RTL

Parametrised successor to the matrix element adder used behind the CPU custom-instruction port. It accepts element pairs, computes add or subtract in a fixed-latency internal pipeline, and buffers results in an internal FIFO until the CPU retrieves them. New over the previous generation:
- configurable data width, FIFO depth and pipeline latency;
- subtract mode and optional signed saturation;
- credit-based overflow rejection and underflow reporting (no deadlock);
- a status query.

---
 rtl/matrix_elem_alu_if.sv | 13 +
 rtl/matrix_elem_alu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/matrix_elem_alu_if.sv
// Command/response port between the CPU custom-instruction slot and matrix_elem_alu.
interface matrix_elem_alu_if #(parameter int DATA_W = 32);
  logic              clk_en;
  logic              start;
  logic [7:0]        n;
  logic [DATA_W-1:0] dataa;
  logic [DATA_W-1:0] datab;
  logic [DATA_W-1:0] result;
  logic              done;

  modport master (output clk_en, start, n, dataa, datab, input result, done);
  modport slave  (input clk_en, start, n, dataa, datab, output result, done);
endinterface

// File: rtl/matrix_elem_alu.sv
// Element add/sub unit: fixed-latency arithmetic pipeline feeding a result FIFO,
// with credit-checked pushes, blocking GET, CLEAR and STATUS commands.
module matrix_elem_alu #(
  parameter int DATA_W   = 32,
  parameter int FIFO_AW  = 4,
  parameter int PIPE_LAT = 3,
  parameter int SATURATE = 0,
  parameter int N_OFFSET = 0
) (
  input logic              clk,
  input logic              reset,
  matrix_elem_alu_if.slave bus
);
  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam int          CW      = FIFO_AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] C_ADD  = 8'd0;
  localparam logic [7:0] C_SUB  = 8'd1;
  localparam logic [7:0] C_GET  = 8'd2;
  localparam logic [7:0] C_CLR  = 8'd3;
  localparam logic [7:0] C_STAT = 8'd4;

  typedef struct packed {
    logic [7:0]        code;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  req_t              req;
  logic [1:0]        state;
  logic [CW-1:0]     fifo_cnt, infl_cnt;
  logic [CW:0]       occ;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PIPE_LAT:1] vld_pipe;
  logic [DATA_W-1:0] pipe_data [1:PIPE_LAT];
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] arith, resp, result_q;
  logic              done_q, ovf_f, unf_f, err_f;
  logic              accept, can_push, is_push, issue, clear, pop, wr, fifo_empty, is_get, get_wait;

  assign req.code = bus.n - 8'(N_OFFSET);
  assign req.a    = bus.dataa;
  assign req.b    = bus.datab;

  assign occ        = {1'b0, fifo_cnt} + {1'b0, infl_cnt};
  assign can_push   = occ < DEPTH_V;
  assign fifo_empty = (fifo_cnt == '0);
  assign accept     = bus.start & bus.clk_en & (state == S_IDLE);
  assign is_push    = accept & ((req.code == C_ADD) | (req.code == C_SUB));
  assign issue      = is_push & can_push;
  assign clear      = accept & (req.code == C_CLR);
  assign is_get     = accept & (req.code == C_GET);
  assign get_wait   = is_get & fifo_empty & (infl_cnt != '0);
  assign pop        = (is_get & ~fifo_empty) | ((state == S_WAIT) & ~fifo_empty);
  // CLEAR on the same edge as a pipeline exit discards that element too
  assign wr         = vld_pipe[PIPE_LAT] & ~clear;

  // Sign-extended by one bit so overflow shows as disagreement of the top two bits
  always_comb begin
    if (req.code == C_SUB) sum = {req.a[DATA_W-1], req.a} - {req.b[DATA_W-1], req.b};
    else                   sum = {req.a[DATA_W-1], req.a} + {req.b[DATA_W-1], req.b};
    arith = sum[DATA_W-1:0];
    if ((SATURATE != 0) && (sum[DATA_W] != sum[DATA_W-1]))
      arith = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      vld_pipe <= '0;
    else if (clear) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= issue;
      for (int k = 2; k <= PIPE_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_data[1] <= arith;
    for (int k = 2; k <= PIPE_LAT; k++) pipe_data[k] <= pipe_data[k-1];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= pipe_data[PIPE_LAT];
  end

  // Credit is taken at issue (infl_cnt) and handed to fifo_cnt on the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      infl_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      infl_cnt <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(wr) - CW'(pop);
      infl_cnt <= infl_cnt + CW'(issue) - CW'(vld_pipe[PIPE_LAT]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_f <= 1'b0;
      unf_f <= 1'b0;
      err_f <= 1'b0;
    end else if (clear) begin
      ovf_f <= 1'b0;
      unf_f <= 1'b0;
      err_f <= 1'b0;
    end else begin
      if (is_push & ~can_push)                         ovf_f <= 1'b1;
      if (is_get & fifo_empty & (infl_cnt == '0))      unf_f <= 1'b1;
      if (accept & (req.code > C_STAT))                err_f <= 1'b1;
    end
  end

  always_comb begin
    resp = '0;
    case (req.code)
      C_ADD, C_SUB: resp[0] = ~can_push;
      C_GET:        if (!fifo_empty) resp = mem[rd_ptr];
      C_STAT: begin
        resp[7:0]  = 8'(fifo_cnt);
        resp[15:8] = 8'(infl_cnt);
        resp[16]   = (occ == DEPTH_V);
        resp[17]   = fifo_empty;
        resp[18]   = ovf_f;
        resp[19]   = unf_f;
        resp[20]   = err_f;
      end
      default:      resp = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (get_wait) state <= S_WAIT;
          else begin
            state    <= S_RESP;
            done_q   <= 1'b1;
            result_q <= resp;
          end
        end
        S_WAIT: if (!fifo_empty) begin
          state    <= S_RESP;
          done_q   <= 1'b1;
          result_q <= mem[rd_ptr];
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule
